inventory_store: RTL and testbench

- Responder end of the inventory front-end's command interface.
- Owns the per-item quantity storage and executes add, remove and read commands as read-modify-write.
- Applies saturation and underflow rules to each command.
- Returns the resulting quantity and a status code through a response handshake.
- Sits between the switch/button front-end (initiator) and the display path.

---
 rtl/inventory_store_pkg.sv | 31 +++
 rtl/inventory_store_ram.sv | 27 ++
 rtl/inventory_store.sv | 183 ++++++++++++++++++
 tb/tb_inventory_store.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/inventory_store_pkg.sv
// rtl/inventory_store_pkg.sv - shared types and default widths for the inventory store
package inv_pkg;

  localparam int unsigned INV_ADDR_W = 8;
  localparam int unsigned INV_DATA_W = 8;

  // Command opcodes; encoding 2'b11 is reserved and executes as a read.
  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_ADD    = 2'b01,
    OP_REMOVE = 2'b10
  } op_e;

  // Response status codes.
  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_SAT   = 2'b01,
    ST_UNDER = 2'b10
  } status_e;

  // Controller states.
  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    READ   = 3'd2,
    MODIFY = 3'd3,
    WRITE  = 3'd4,
    RESP   = 3'd5
  } state_e;

endpackage

// File: rtl/inventory_store_ram.sv
// rtl/inventory_store_ram.sv - single-port quantity storage with registered read
module inv_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  // The array has no reset; the controller's INIT sweep clears it.
  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // Write-first-free storage: write on we, read data registered every cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inventory_store.sv
// rtl/inventory_store.sv - read-modify-write quantity store; option macro INV_UNDERFLOW_CLAMP_EN
module inventory_store
  import inv_pkg::*;
#(
  parameter int ADDR_W = INV_ADDR_W,
  parameter int DATA_W = INV_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_code,
  input  logic [DATA_W-1:0] req_quant,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_qty,
  output logic [1:0]        rsp_status,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] code_q, code_d;
  logic [DATA_W-1:0] quant_q, quant_d;
  logic [DATA_W-1:0] new_q, new_d;
  logic [1:0]        status_q, status_d;
  logic              wr_due_q, wr_due_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_qty_q, rsp_qty_d;
  logic [1:0]        rsp_status_q, rsp_status_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // One extra bit catches both carry-out (saturation) and borrow (underflow).
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  assign sum  = {1'b0, ram_rdata} + {1'b0, quant_q};
  assign diff = {1'b0, ram_rdata} - {1'b0, quant_q};

  inv_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Register all controller state; reset restarts the clearing sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      op_q         <= OP_READ;
      code_q       <= '0;
      quant_q      <= '0;
      new_q        <= '0;
      status_q     <= ST_OK;
      wr_due_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_qty_q    <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      op_q         <= op_d;
      code_q       <= code_d;
      quant_q      <= quant_d;
      new_q        <= new_d;
      status_q     <= status_d;
      wr_due_q     <= wr_due_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_qty_q    <= rsp_qty_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  // Next-state, RAM port control and the saturation/underflow arithmetic.
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    op_d         = op_q;
    code_d       = code_q;
    quant_d      = quant_q;
    new_d        = new_q;
    status_d     = status_q;
    wr_due_d     = wr_due_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_qty_d    = rsp_qty_q;
    rsp_status_d = rsp_status_q;
    ram_we       = 1'b0;
    ram_addr     = code_q;
    ram_wdata    = new_q;

    unique case (state_q)
      INIT: begin
        ram_we    = 1'b1;
        ram_addr  = sweep_q;
        ram_wdata = '0;
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == {ADDR_W{1'b1}}) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        ram_addr = req_code;
        if (req_valid) begin
          op_d    = req_op;
          code_d  = req_code;
          quant_d = req_quant;
          state_d = READ;
        end
      end
      READ: begin
        state_d = MODIFY;
      end
      MODIFY: begin
        state_d = WRITE;
        case (op_q)
          OP_ADD: begin
            wr_due_d = 1'b1;
            if (sum[DATA_W]) begin
              new_d    = {DATA_W{1'b1}};
              status_d = ST_SAT;
            end else begin
              new_d    = sum[DATA_W-1:0];
              status_d = ST_OK;
            end
          end
          OP_REMOVE: begin
            if (diff[DATA_W]) begin
              status_d = ST_UNDER;
`ifdef INV_UNDERFLOW_CLAMP_EN
              new_d    = '0;
              wr_due_d = 1'b1;
`else
              new_d    = ram_rdata;
              wr_due_d = 1'b0;
`endif
            end else begin
              new_d    = diff[DATA_W-1:0];
              status_d = ST_OK;
              wr_due_d = 1'b1;
            end
          end
          default: begin
            new_d    = ram_rdata;
            status_d = ST_OK;
            wr_due_d = 1'b0;
          end
        endcase
      end
      WRITE: begin
        ram_we       = wr_due_q;
        rsp_qty_d    = new_q;
        rsp_status_d = status_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_qty    = rsp_qty_q;
  assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_inventory_store.sv
// tb/tb_inventory_store.sv - directed self-checking bench for inventory_store
`timescale 1ns/1ps
module tb_inventory_store;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_code;
  logic [7:0] req_quant;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_qty;
  logic [1:0] rsp_status;
  logic       busy;

  int errors = 0;
  int checks = 0;

`ifdef INV_UNDERFLOW_CLAMP_EN
  localparam logic [7:0] UNDER_QTY = 8'd0;
`else
  localparam logic [7:0] UNDER_QTY = 8'd5;
`endif

  inventory_store dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_code   (req_code),
    .req_quant  (req_quant),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_qty    (rsp_qty),
    .rsp_status (rsp_status),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait out the 256-entry clear sweep; ready must rise on exactly the 256th edge.
  task automatic check_sweep(input string tag);
    int rv_seen;
    rv_seen = 0;
    for (int i = 0; i < 255; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || req_ready) rv_seen++;
    end
    check({tag, "_ready_early"}, rv_seen, 0);
    @(posedge clk);
    #1;
    check({tag, "_ready_after"}, req_ready, 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic wait_rsp(input string tag, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 20) check({tag, "_rsp_timeout"}, 0, 1);
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [7:0] code,
                        input logic [7:0] quant, input logic [7:0] exp_qty,
                        input logic [1:0] exp_st);
    int n;
    n = 0;
    while (!req_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_code  = code;
    req_quant = quant;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_code  = 8'($urandom);
    req_quant = 8'($urandom);
    wait_rsp(tag, n);
    check({tag, "_latency"}, n, 3);
    check({tag, "_qty"}, rsp_qty, exp_qty);
    check({tag, "_status"}, rsp_status, exp_st);
    @(posedge clk);
    #1;
    check({tag, "_rsp_drop"}, rsp_valid, 0);
  endtask

  initial begin
    int lat;
    int bad;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_code  = 8'h00;
    req_quant = 8'h00;
    rsp_ready = 1'b1;

    // Reset state
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_qty", rsp_qty, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_busy", busy, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_sweep("sweep1");

    // Fresh store reads zero
    do_cmd("read37", 2'b00, 8'h37, 8'h00, 8'd0, 2'b00);

    // Accumulate and saturate
    do_cmd("add1", 2'b01, 8'h10, 8'd100, 8'd100, 2'b00);
    do_cmd("add2", 2'b01, 8'h10, 8'd100, 8'd200, 2'b00);
    do_cmd("add3", 2'b01, 8'h10, 8'd100, 8'd255, 2'b01);
    do_cmd("read10", 2'b00, 8'h10, 8'h00, 8'd255, 2'b00);

    // Remove down to exactly zero
    do_cmd("rem1", 2'b10, 8'h10, 8'd55, 8'd200, 2'b00);
    do_cmd("rem2", 2'b10, 8'h10, 8'd200, 8'd0, 2'b00);

    // Underflow handling and zero operands
    do_cmd("add20", 2'b01, 8'h20, 8'd5, 8'd5, 2'b00);
    do_cmd("add0", 2'b01, 8'h20, 8'd0, 8'd5, 2'b00);
    do_cmd("rem0", 2'b10, 8'h20, 8'd0, 8'd5, 2'b00);
    do_cmd("rsvd", 2'b11, 8'h20, 8'd77, 8'd5, 2'b00);
    do_cmd("under", 2'b10, 8'h20, 8'd6, UNDER_QTY, 2'b10);
    do_cmd("read20", 2'b00, 8'h20, 8'h00, UNDER_QTY, 2'b00);

    // Response back-pressure with a competing request held
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_code  = 8'h30;
    req_quant = 8'd1;
    @(posedge clk);
    #1;
    req_quant = 8'd2;
    wait_rsp("bp1", lat);
    check("bp1_latency", lat, 3);
    check("bp1_qty", rsp_qty, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!rsp_valid || rsp_qty !== 8'd1 || rsp_status !== 2'b00 || req_ready) bad++;
    end
    check("bp_hold_stable", bad, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ready", req_ready, 1);
    check("bp_release_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    check("bp_second_taken", busy, 1);
    req_valid = 1'b0;
    wait_rsp("bp2", lat);
    check("bp2_latency", lat, 3);
    check("bp2_qty", rsp_qty, 3);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) bad++;
    end
    check("bp_only_one", bad, 0);
    check("bp_idle", busy, 0);
    do_cmd("read30", 2'b00, 8'h30, 8'h00, 8'd3, 2'b00);

    // Reset during MODIFY of an ADD
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_code  = 8'h01;
    req_quant = 8'd9;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_busy", busy, 1);
    check("mid_ready", req_ready, 0);
    #1;
    rst_n = 1'b1;
    check_sweep("sweep2");
    check("sweep2_no_rsp", rsp_valid, 0);
    do_cmd("read01", 2'b00, 8'h01, 8'h00, 8'd0, 2'b00);
    do_cmd("read30_clr", 2'b00, 8'h30, 8'h00, 8'd0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
